// File: rtl/data_load_receiver_pkg.sv
// Shared definitions for the feature-map / weight load receiver.
// Holds the default bus geometry, the burst length expected on the fm
// channel, the weight bank split address and the channel FSM encoding.
package data_load_receiver_pkg;

    localparam int DATA_WIDTH              = 8;
    localparam int PARA_X                  = 3;
    localparam int PARA_Y                  = 3;
    localparam int KERNEL_SIZE_MAX         = 3;
    localparam int PARA_KERNEL             = 2;
    localparam int WRITE_ADDR_WIDTH        = 8;
    localparam int WEIGHT_WRITE_ADDR_WIDTH = 5;

    localparam int FM_DW_DEF = PARA_X * PARA_Y * DATA_WIDTH;
    localparam int FM_AW_DEF = WRITE_ADDR_WIDTH;
    localparam int W_DW_DEF  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * PARA_KERNEL * DATA_WIDTH;
    localparam int W_AW_DEF  = WEIGHT_WRITE_ADDR_WIDTH * PARA_KERNEL;

    localparam int FM_WORDS_DEF = 18;
    localparam int W_HALF_DEF   = 256;

    localparam logic [5:0] CNT_MAX = 6'd63;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RECV  = 2'd1,
        CH_CLOSE = 2'd2
    } ch_state_e;

    // Word counter increment that holds at its maximum.
    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + 6'd1;
    endfunction

endpackage

// File: rtl/data_load_receiver_load_channel.sv
// One receive channel (used for both fm and weight traffic).
// Registers the loader bus, runs the IDLE/RECV/CLOSE burst FSM, drops
// repeated addresses so each held word is written once, counts writes and
// drives registered RAM write outputs (write visible two cycles after input).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_data/in_addr     loader word and address
//   in_done             0 while a transfer is active
//   wr_en/wr_addr/wr_data  registered RAM write port
//   word_cnt            words written in current/last burst (saturating)
//   cnt_sat             a write was attempted with the counter at maximum
//   burst_start         combinational: IDLE->RECV this cycle
//   burst_close         channel is in CLOSE this cycle
module load_channel
    import data_load_receiver_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_addr,
    input  logic          in_done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [5:0]    word_cnt,
    output logic          cnt_sat,
    output logic          burst_start,
    output logic          burst_close
);

    logic [DW-1:0] s_data_q;
    logic [AW-1:0] s_addr_q;
    logic          s_done_q;
    ch_state_e     state_q, state_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          start;

    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        wr_en_d     = 1'b0;
        start       = 1'b0;
        case (state_q)
            CH_IDLE: begin
                // A new done=0 window re-arms dedupe: first word always written.
                if (!s_done_q) begin
                    state_d     = CH_RECV;
                    start       = 1'b1;
                    wr_en_d     = 1'b1;
                    last_addr_d = s_addr_q;
                    cnt_d       = 6'd1;
                    sat_d       = 1'b0;
                end
            end
            CH_RECV: begin
                // The word sampled together with done=1 is dropped.
                if (s_done_q) begin
                    state_d = CH_CLOSE;
                end else if (s_addr_q != last_addr_q) begin
                    wr_en_d     = 1'b1;
                    last_addr_d = s_addr_q;
                    if (cnt_q == CNT_MAX) sat_d = 1'b1;
                    cnt_d       = sat_inc(cnt_q);
                end
            end
            CH_CLOSE: state_d = CH_IDLE;
            default:  state_d = CH_IDLE;
        endcase
        wr_addr_d = wr_en_d ? s_addr_q : wr_addr_q;
        wr_data_d = wr_en_d ? s_data_q : wr_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_data_q    <= '0;
            s_addr_q    <= '0;
            s_done_q    <= 1'b1;
            state_q     <= CH_IDLE;
            last_addr_q <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            s_data_q    <= in_data;
            s_addr_q    <= in_addr;
            s_done_q    <= in_done;
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign word_cnt    = cnt_q;
    assign cnt_sat     = sat_q;
    assign burst_start = start;
    assign burst_close = (state_q == CH_CLOSE);

endmodule

// File: rtl/data_load_receiver.sv
// Receiving end of the fm / weight load interface.
// Two load_channel instances write the fm and weight RAMs; this level
// checks fm burst completeness, tracks which weight banks hold fresh data
// and pulses conv_start when both fm and some weight bank become ready.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   fm_data/fm_addr/fm_done      fm loader bus (fm_done=0: transfer active)
//   w_data/w_addr/w_done         weight loader bus
//   bank_release[1:0]            conv engine consumed a weight bank (pulse)
//   fm_wr_*/w_wr_*               RAM write ports
//   fm_ready, w_bank_ready[1:0]  buffer readiness
//   fm_word_cnt[5:0]             words in current/last fm burst
//   load_error                   sticky bad fm burst flag
//   conv_start                   one-cycle start pulse for the conv engine
module data_load_receiver
    import data_load_receiver_pkg::*;
#(
    parameter int FM_DW    = FM_DW_DEF,
    parameter int FM_AW    = FM_AW_DEF,
    parameter int W_DW     = W_DW_DEF,
    parameter int W_AW     = W_AW_DEF,
    parameter int FM_WORDS = FM_WORDS_DEF,
    parameter int W_HALF   = W_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FM_DW-1:0] fm_data,
    input  logic [FM_AW-1:0] fm_addr,
    input  logic             fm_done,
    input  logic [W_DW-1:0]  w_data,
    input  logic [W_AW-1:0]  w_addr,
    input  logic             w_done,
    input  logic [1:0]       bank_release,
    output logic             fm_wr_en,
    output logic [FM_AW-1:0] fm_wr_addr,
    output logic [FM_DW-1:0] fm_wr_data,
    output logic             w_wr_en,
    output logic [W_AW-1:0]  w_wr_addr,
    output logic [W_DW-1:0]  w_wr_data,
    output logic             fm_ready,
    output logic [1:0]       w_bank_ready,
    output logic [5:0]       fm_word_cnt,
    output logic             load_error,
    output logic             conv_start
);

    logic       fm_sat, fm_start, fm_close;
    logic [5:0] w_cnt;
    logic       w_sat, w_start, w_close;
    logic       unused_w;

    load_channel #(.DW(FM_DW), .AW(FM_AW)) u_fm (
        .clk(clk), .rst(rst),
        .in_data(fm_data), .in_addr(fm_addr), .in_done(fm_done),
        .wr_en(fm_wr_en), .wr_addr(fm_wr_addr), .wr_data(fm_wr_data),
        .word_cnt(fm_word_cnt), .cnt_sat(fm_sat),
        .burst_start(fm_start), .burst_close(fm_close)
    );

    load_channel #(.DW(W_DW), .AW(W_AW)) u_w (
        .clk(clk), .rst(rst),
        .in_data(w_data), .in_addr(w_addr), .in_done(w_done),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .word_cnt(w_cnt), .cnt_sat(w_sat),
        .burst_start(w_start), .burst_close(w_close)
    );

    assign unused_w = ^{w_cnt, w_sat};

    logic       fm_ready_q, fm_ready_d;
    logic       load_error_q, load_error_d;
    logic [1:0] pending_q, pending_d;
    logic [1:0] bank_ready_q, bank_ready_d;
    logic       both_q, both_d;
    logic       conv_start_q, conv_start_d;
    logic       w_bank;

    assign w_bank = (w_wr_addr >= W_AW'(W_HALF));

    always_comb begin
        fm_ready_d   = fm_ready_q;
        load_error_d = load_error_q;
        if (fm_start) fm_ready_d = 1'b0;
        if (fm_sat)   load_error_d = 1'b1;
        if (fm_close) begin
            if (fm_word_cnt == 6'(FM_WORDS) && !fm_sat) begin
                fm_ready_d   = 1'b1;
                load_error_d = 1'b0;
            end else begin
                fm_ready_d   = 1'b0;
                load_error_d = 1'b1;
            end
        end

        // Pending tracks banks touched by the current weight burst; the
        // registered write strobe lands before CLOSE, so CLOSE sees it all.
        pending_d = pending_q;
        if (w_start) pending_d = 2'b00;
        if (w_wr_en) pending_d[w_bank] = 1'b1;

        // Release first, then CLOSE sets: a same-cycle set wins.
        bank_ready_d = bank_ready_q & ~bank_release;
        if (w_close) bank_ready_d = bank_ready_d | pending_q;

        both_d       = fm_ready_q & (|bank_ready_q);
        conv_start_d = both_d & ~both_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fm_ready_q   <= 1'b0;
            load_error_q <= 1'b0;
            pending_q    <= 2'b00;
            bank_ready_q <= 2'b00;
            both_q       <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            fm_ready_q   <= fm_ready_d;
            load_error_q <= load_error_d;
            pending_q    <= pending_d;
            bank_ready_q <= bank_ready_d;
            both_q       <= both_d;
            conv_start_q <= conv_start_d;
        end
    end

    assign fm_ready     = fm_ready_q;
    assign load_error   = load_error_q;
    assign w_bank_ready = bank_ready_q;
    assign conv_start   = conv_start_q;

endmodule
